axi_burst_slave: RTL and testbench

AXI_BURST_SLAVE -- requirements
Module: axi_burst_slave
Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16, number of 32-bit words in internal memory (power of two, 4..256).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 ACLK  in  1  clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset, synchronous, active-low.
REQ-005 S_AXI_AWID  in  4  write burst ID.
REQ-006 S_AXI_AWADDR  in  32  write start byte address.
REQ-007 S_AXI_AWLEN  in  8  beats minus one.
REQ-008 S_AXI_AWBURST  in  2  burst type.
REQ-009 S_AXI_AWVALID  in  1  AW valid.
REQ-010 S_AXI_AWREADY  out  1  AW ready.
REQ-011 S_AXI_WDATA  in  32  write data.
REQ-012 S_AXI_WSTRB  in  4  byte enables.
REQ-013 S_AXI_WLAST  in  1  last write beat.
REQ-014 S_AXI_WVALID  in  1  W valid.
REQ-015 S_AXI_WREADY  out  1  W ready.
REQ-016 S_AXI_BID  out  4  response ID.
REQ-017 S_AXI_BRESP  out  2  write response.
REQ-018 S_AXI_BVALID  out  1  B valid.
REQ-019 S_AXI_BREADY  in  1  B ready.
REQ-020 S_AXI_ARID  in  4  read burst ID.
REQ-021 S_AXI_ARADDR  in  32  read start byte address.
REQ-022 S_AXI_ARLEN  in  8  beats minus one.
REQ-023 S_AXI_ARBURST  in  2  burst type.
REQ-024 S_AXI_ARVALID  in  1  AR valid.
REQ-025 S_AXI_ARREADY  out  1  AR ready.
REQ-026 S_AXI_RID  out  4  read ID.
REQ-027 S_AXI_RDATA  out  32  read data.
REQ-028 S_AXI_RRESP  out  2  read response.
REQ-029 S_AXI_RLAST  out  1  last read beat.
REQ-030 S_AXI_RVALID  out  1  R valid.
REQ-031 S_AXI_RREADY  in  1  R ready; SIZE/PROT/CACHE/LOCK/QOS/REGION are not ports (beats are always 4 bytes).
Function
REQ-032 Write FSM W_IDLE/W_DATA/W_RESP SHALL be independent of read FSM R_IDLE/R_DATA; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP; W beats are never accepted before AW handshake.
REQ-033 AW handshake SHALL latch ID/ADDR/LEN/BURST and enter W_DATA next cycle; each W handshake writes bytes selected by WSTRB, then INCR adds 4 to address, FIXED holds it.
REQ-034 W handshake with WLAST=1 SHALL enter W_RESP next cycle with BID=latched AWID; BVALID/BID/BRESP held stable until BREADY, then W_IDLE (AWREADY=1 the following cycle).
REQ-035 BRESP SHALL be SLVERR (2'b10) if BURST=WRAP or RESERVED, any beat address outside BASE_ADDR..BASE_ADDR+4*MEM_WORDS-1, or WLAST beat count != AWLEN+1; else OKAY; erroneous beats write nothing.
REQ-036 AR handshake SHALL latch ID/ADDR/LEN/BURST and enter R_DATA with RVALID=1 next cycle, RDATA=word at current address, RID=ARID, RLAST=1 on beat ARLEN.
REQ-037 RDATA/RRESP/RLAST/RID SHALL hold stable while RVALID=1 and RREADY=0; each R handshake advances address (INCR +4, FIXED hold) and presents next beat the following cycle; last handshake returns to R_IDLE.
REQ-038 Read beats out of range or with WRAP/RESERVED burst SHALL return RDATA=0, RRESP=SLVERR; all other beats OKAY.
REQ-039 Same-cycle write handshake and read beat load to one word SHALL return pre-write data; address low two bits SHALL be ignored; AWLEN/ARLEN=255 (256 beats) SHALL be supported with 9-bit beat counters.
REQ-040 Address increment SHALL be 32-bit modulo 2^32; the wrapped address is out of range and errors per REQ-035/038.
Reset
REQ-041 ARESETn=0 SHALL force W_IDLE/R_IDLE, AWREADY=ARREADY=0 for one cycle then 1, WREADY=BVALID=RVALID=RLAST=0, BRESP=RRESP=0, BID=RID=0, RDATA=0; memory contents are not cleared; reset mid-burst abandons the burst with no response.
Structure
REQ-042 Burst-type (FIXED=0, INCR=1, WRAP=2) and response (OKAY=0, SLVERR=2) constants SHALL live in shared package axi_pkg, reused by the master.
REQ-043 Storage SHALL be one sub-module axi_slave_mem (byte-enabled write port, one synchronous read port); no other sub-modules.
Verification
REQ-044 AW 0x4 LEN=3 INCR, W 0x10000000..0x10000003 with WLAST on beat 4, BREADY=1 -> BRESP OKAY, BID=AWID; AR 0x4 LEN=3 -> RDATA 0x10000000..03, RLAST on beat 4 only.
REQ-045 RREADY toggled 1/0 each cycle during 4-beat read -> RDATA/RLAST stable while stalled, no beat lost or duplicated; BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY stays 0.
REQ-046 AW 0x3C LEN=1 INCR (MEM_WORDS=16) -> word 15 written, beat 2 dropped, BRESP SLVERR; AR 0x3C LEN=1 -> beat1 OKAY, beat2 RDATA 0 SLVERR; WSTRB 4'b0101 write -> only bytes 0,2 change.
REQ-047 FIXED burst LEN=2 to 0x8 -> final word = beat 3 data; ARESETn pulsed mid-write -> BVALID=0, AWREADY=1 one cycle after release, next burst OKAY.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_slave_mem.sv | 27 ++
 rtl/axi_burst_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_burst_slave.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings used by both master and slave sides of the codebase.
// Burst types, response codes and a burst-support helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word-organised storage for the burst slave: byte-enabled write port and
// one registered read port (read returns pre-write data on same-word collision).
module axi_slave_mem #(
  parameter int unsigned WORDS = 16
) (
  input  logic                       ACLK,
  input  logic                       we,
  input  logic [3:0]                 wstrb,
  input  logic [$clog2(WORDS)-1:0]   waddr,
  input  logic [31:0]                wdata,
  input  logic                       re,
  input  logic [$clog2(WORDS)-1:0]   raddr,
  output logic [31:0]                rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge ACLK) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI4 burst slave with independent write (AW/W/B) and read (AR/R) engines
// over a small internal word memory; FIXED and INCR bursts, 4-byte beats.
module axi_burst_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [3:0]  S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [3:0]  S_AXI_RID,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int unsigned IDX_W        = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN         = 32'(4 * MEM_WORDS);
  localparam logic [31:0] BASE_ALIGNED = {BASE_ADDR[31:2], 2'b00};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     init_done;

  logic [3:0]  aw_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [1:0]  w_burst;
  logic [8:0]  w_cnt;
  logic        w_wrapped, w_over, w_err;
  logic [1:0]  b_resp;

  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [8:0]  r_cnt;
  logic        r_wrapped, r_err;

  logic        aw_hs, w_hs, ar_hs, r_hs, r_last, r_incr;
  logic [32:0] w_addr_inc, r_addr_inc;
  logic [31:0] w_off, r_nxt_addr, ld_addr, ld_off;
  logic [1:0]  ld_burst;
  logic        w_beat_bad, r_nxt_wrap, ld_wrap, ld_bad, mem_we, mem_re;
  logic [31:0] mem_rdata;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

  // Low address bits survive the subtraction but cannot affect a compare against a multiple of 4.
  assign w_addr_inc = {1'b0, w_addr} + 33'd4;
  assign w_off      = w_addr - BASE_ALIGNED;
  assign w_beat_bad = !burst_supported(w_burst) || w_wrapped || w_over || (w_off >= SPAN);
  assign mem_we     = w_hs && !w_beat_bad;

  assign r_incr     = (r_burst == BURST_INCR);
  assign r_last     = (r_cnt == {1'b0, r_len});
  assign r_addr_inc = {1'b0, r_addr} + 33'd4;
  assign r_nxt_addr = r_incr ? r_addr_inc[31:0] : r_addr;
  assign r_nxt_wrap = r_wrapped || (r_incr && r_addr_inc[32]);

  // The read port is loaded one cycle ahead: from AR on the address handshake, else the next beat.
  assign ld_addr  = (r_state == R_IDLE) ? S_AXI_ARADDR  : r_nxt_addr;
  assign ld_burst = (r_state == R_IDLE) ? S_AXI_ARBURST : r_burst;
  assign ld_wrap  = (r_state == R_IDLE) ? 1'b0          : r_nxt_wrap;
  assign ld_off   = ld_addr - BASE_ALIGNED;
  assign ld_bad   = !burst_supported(ld_burst) || ld_wrap || (ld_off >= SPAN);
  assign mem_re   = ar_hs || (r_hs && !r_last);

  axi_slave_mem #(.WORDS(MEM_WORDS)) u_mem (
    .ACLK  (ACLK),
    .we    (mem_we),
    .wstrb (S_AXI_WSTRB),
    .waddr (w_off[IDX_W+1:2]),
    .wdata (S_AXI_WDATA),
    .re    (mem_re),
    .raddr (ld_off[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      init_done <= 1'b0;
    end else begin
      w_state   <= w_state_nxt;
      r_state   <= r_state_nxt;
      init_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = init_done;
        if (S_AXI_AWVALID && init_done) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && S_AXI_WLAST) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = init_done;
        if (S_AXI_ARVALID && init_done) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY && r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_id     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_wrapped <= 1'b0;
      w_over    <= 1'b0;
      w_err     <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else if (aw_hs) begin
      aw_id     <= S_AXI_AWID;
      w_addr    <= S_AXI_AWADDR;
      w_len     <= S_AXI_AWLEN;
      w_burst   <= S_AXI_AWBURST;
      w_cnt     <= '0;
      w_wrapped <= 1'b0;
      w_over    <= 1'b0;
      w_err     <= 1'b0;
    end else if (w_hs) begin
      if (w_burst == BURST_INCR) begin
        w_addr    <= w_addr_inc[31:0];
        w_wrapped <= w_wrapped || w_addr_inc[32];
      end
      w_cnt <= w_cnt + 9'd1;
      if (w_cnt == {1'b0, w_len} && !S_AXI_WLAST) w_over <= 1'b1;
      w_err <= w_err || w_beat_bad;
      if (S_AXI_WLAST)
        b_resp <= (w_err || w_beat_bad || (w_cnt != {1'b0, w_len})) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
    end else if (ar_hs) begin
      r_id      <= S_AXI_ARID;
      r_addr    <= S_AXI_ARADDR;
      r_len     <= S_AXI_ARLEN;
      r_burst   <= S_AXI_ARBURST;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
      r_err     <= ld_bad;
    end else if (r_hs && !r_last) begin
      r_addr    <= r_nxt_addr;
      r_wrapped <= r_nxt_wrap;
      r_cnt     <= r_cnt + 9'd1;
      r_err     <= ld_bad;
    end
  end

  assign S_AXI_BID   = aw_id;
  assign S_AXI_BRESP = b_resp;
  assign S_AXI_RID   = r_id;
  assign S_AXI_RLAST = (r_state == R_DATA) && r_last;
  assign S_AXI_RDATA = ((r_state == R_DATA) && !r_err) ? mem_rdata : '0;
  assign S_AXI_RRESP = ((r_state == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Scoreboard bench for axi_burst_slave: stimulus pushes expected B/R responses
// from a word-array reference model; a negedge monitor pops and compares.
module tb_axi_burst_slave;
  import axi_pkg::*;

  localparam int unsigned MW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  axi_burst_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
    .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bresp_t;

  rbeat_t      rq[$];
  bresp_t      bq[$];
  logic [31:0] model [MW];
  logic [31:0] wd[$];
  logic [3:0]  ws[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference address rules: 64-bit arithmetic exposes the 2^32 wrap directly.
  function automatic bit beat_bad(input logic [31:0] addr, input logic [1:0] burst, input int i);
    longint unsigned a;
    a = 64'(addr & 32'hFFFF_FFFC);
    if (burst == BURST_INCR) a = a + 64'(4 * i);
    if (burst != BURST_FIXED && burst != BURST_INCR) return 1'b1;
    return (a >= 64'h1_0000_0000) || (a < 64'(BASE)) || (a >= 64'(BASE) + 64'(4 * MW));
  endfunction

  function automatic int word_idx(input logic [31:0] addr, input logic [1:0] burst, input int i);
    longint unsigned a;
    a = 64'(addr & 32'hFFFF_FFFC);
    if (burst == BURST_INCR) a = a + 64'(4 * i);
    return int'((a - 64'(BASE)) >> 2);
  endfunction

  task automatic fill(input int n, input bit seq, input logic [31:0] start,
                      input bit strb_rand, input logic [3:0] strb);
    wd.delete();
    ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back(seq ? start + 32'(i) : $urandom);
      ws.push_back(strb_rand ? 4'($urandom_range(0, 15)) : strb);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int bready_delay);
    bit     any_bad;
    bresp_t be;
    int     n;
    int     idx;
    any_bad = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (beat_bad(addr, burst, i)) any_bad = 1'b1;
      else begin
        idx = word_idx(addr, burst, i);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    be.id   = id;
    be.resp = any_bad ? RESP_SLVERR : RESP_OKAY;
    bq.push_back(be);
    BREADY = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin tick(); n++; end
    if (!AWREADY) fail("aw_timeout");
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == int'(len)); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin tick(); n++; end
      if (!WREADY) fail("w_timeout");
      tick();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    repeat (bready_delay) tick();
    BREADY = 1'b1;
    n = 0;
    while (bq.size() != 0 && n < 50) begin tick(); n++; end
    if (bq.size() != 0) begin fail("b_timeout"); bq.delete(); end
    BREADY = 1'b0;
  endtask

  // mode 0: RREADY held high, 1: toggles every cycle, 2: random
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode);
    rbeat_t rb;
    int     n;
    for (int i = 0; i <= int'(len); i++) begin
      rb.id   = id;
      rb.last = (i == int'(len));
      if (beat_bad(addr, burst, i)) begin
        rb.data = '0;
        rb.resp = RESP_SLVERR;
      end else begin
        rb.data = model[word_idx(addr, burst, i)];
        rb.resp = RESP_OKAY;
      end
      rq.push_back(rb);
    end
    RREADY = (mode != 1);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin tick(); n++; end
    if (!ARREADY) fail("ar_timeout");
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 2000) begin
      RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (rq.size() != 0) begin fail("r_timeout"); rq.delete(); end
    RREADY = 1'b0;
  endtask

  logic        b_stalled = 1'b0, r_stalled = 1'b0;
  logic [3:0]  b_prev_id;
  logic [1:0]  b_prev_resp;
  rbeat_t      r_prev;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      b_stalled <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      if (b_stalled) begin
        chk("b_hold_valid", 32'(BVALID), 32'd1);
        chk("b_hold_id", 32'(BID), 32'(b_prev_id));
        chk("b_hold_resp", 32'(BRESP), 32'(b_prev_resp));
        chk("awready_in_resp", 32'(AWREADY), 32'd0);
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          chk("bid", 32'(BID), 32'(bq[0].id));
          chk("bresp", 32'(BRESP), 32'(bq[0].resp));
          bq.delete(0);
        end
      end
      if (r_stalled) begin
        chk("r_hold_valid", 32'(RVALID), 32'd1);
        chk("r_hold_data", RDATA, r_prev.data);
        chk("r_hold_last", 32'(RLAST), 32'(r_prev.last));
        chk("r_hold_resp", 32'(RRESP), 32'(r_prev.resp));
        chk("r_hold_id", 32'(RID), 32'(r_prev.id));
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          chk("rid", 32'(RID), 32'(rq[0].id));
          chk("rdata", RDATA, rq[0].data);
          chk("rresp", 32'(RRESP), 32'(rq[0].resp));
          chk("rlast", 32'(RLAST), 32'(rq[0].last));
          rq.delete(0);
        end
      end
      b_stalled   <= BVALID && !BREADY;
      b_prev_id   <= BID;
      b_prev_resp <= BRESP;
      r_stalled   <= RVALID && !RREADY;
      r_prev      <= '{RID, RDATA, RRESP, RLAST};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  bt;
    int          r;

    repeat (3) tick();
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_rid", 32'(RID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    ARESETn = 1'b1;
    chk("release_awready", 32'(AWREADY), 32'd0);
    chk("release_arready", 32'(ARREADY), 32'd0);
    tick();
    chk("post_release_awready", 32'(AWREADY), 32'd1);
    chk("post_release_arready", 32'(ARREADY), 32'd1);

    // Known contents everywhere before any read.
    fill(MW, 1'b0, '0, 1'b0, 4'hF);
    do_write(4'h1, BASE, 8'(MW - 1), BURST_INCR, 0);

    fill(4, 1'b1, 32'h1000_0000, 1'b0, 4'hF);
    do_write(4'h5, 32'h4, 8'd3, BURST_INCR, 0);
    do_read(4'h6, 32'h4, 8'd3, BURST_INCR, 0);
    do_read(4'h7, 32'h4, 8'd3, BURST_INCR, 1);

    fill(2, 1'b0, '0, 1'b0, 4'hF);
    do_write(4'h9, 32'h20, 8'd1, BURST_INCR, 5);

    fill(2, 1'b0, '0, 1'b0, 4'hF);
    do_write(4'hA, 32'h3C, 8'd1, BURST_INCR, 0);
    do_read(4'hB, 32'h3C, 8'd1, BURST_INCR, 0);

    fill(1, 1'b1, 32'hAABB_CCDD, 1'b0, 4'b0101);
    do_write(4'h2, 32'h10, 8'd0, BURST_INCR, 0);
    do_read(4'h3, 32'h10, 8'd0, BURST_INCR, 0);

    fill(3, 1'b1, 32'h5555_0000, 1'b0, 4'hF);
    do_write(4'h4, 32'h8, 8'd2, BURST_FIXED, 0);
    do_read(4'h4, 32'h8, 8'd0, BURST_INCR, 0);

    // Abandon a write burst with reset after two beats.
    AWID = 4'h3; AWADDR = 32'h30; AWLEN = 8'd3; AWBURST = BURST_INCR; AWVALID = 1'b1;
    r = 0;
    while (!AWREADY && r < 50) begin tick(); r++; end
    if (!AWREADY) fail("aw_timeout_rst");
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      r = 0;
      while (!WREADY && r < 50) begin tick(); r++; end
      if (!WREADY) fail("w_timeout_rst");
      model[12 + i] = WDATA;
      tick();
    end
    WVALID = 1'b0;
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    chk("midrst_bvalid", 32'(BVALID), 32'd0);
    chk("midrst_wready", 32'(WREADY), 32'd0);
    chk("midrst_awready_hold", 32'(AWREADY), 32'd0);
    tick();
    chk("midrst_awready", 32'(AWREADY), 32'd1);
    chk("midrst_bvalid_after", 32'(BVALID), 32'd0);
    fill(4, 1'b0, '0, 1'b0, 4'hF);
    do_write(4'hC, 32'h30, 8'd3, BURST_INCR, 0);
    do_read(4'hC, 32'h2C, 8'd4, BURST_INCR, 2);

    fill(2, 1'b0, '0, 1'b0, 4'hF);
    do_write(4'hD, 32'h0, 8'd1, BURST_WRAP, 0);
    do_read(4'hD, 32'h0, 8'd1, BURST_WRAP, 0);
    do_read(4'hE, 32'h4, 8'd0, BURST_RSVD, 0);
    do_read(4'hF, 32'hFFFF_FFFC, 8'd1, BURST_INCR, 0);
    do_read(4'h1, 32'h25, 8'd2, BURST_INCR, 0);

    fill(256, 1'b1, 32'hA000_0000, 1'b0, 4'hF);
    do_write(4'h6, 32'hC, 8'd255, BURST_FIXED, 0);
    do_read(4'h6, 32'hC, 8'd255, BURST_FIXED, 2);
    do_read(4'h7, BASE, 8'(MW - 1), BURST_INCR, 0);

    for (int t = 0; t < 30; t++) begin
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8;
      r = $urandom_range(0, 7);
      bt = (r < 5) ? BURST_INCR : (r < 7) ? BURST_FIXED : 2'($urandom_range(2, 3));
      r = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        fill(r + 1, 1'b0, '0, 1'b1, 4'hF);
        do_write(4'($urandom_range(0, 15)), a, 8'(r), bt, $urandom_range(0, 3));
      end else begin
        do_read(4'($urandom_range(0, 15)), a, 8'(r), bt, 2);
      end
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
